// File: rtl/scr1_tapc_ctrl.sv
// scr1_tapc_ctrl: JTAG TAP controller with IR, BYPASS, DR select decode and TDO mux
module scr1_tapc_ctrl #(
  parameter int SCR1_IR_WIDTH = 5,
  parameter int SCR1_NUM_DR   = 4,
  parameter int SCR1_IR_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tms,
  input  logic                     tdi,
  input  logic [SCR1_NUM_DR-1:0]   dr_dout_serial,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [SCR1_NUM_DR-1:0]   fsm_dr_select,
  output logic                     fsm_dr_capture,
  output logic                     fsm_dr_shift,
  output logic                     fsm_dr_update,
  output logic                     rst_n_sync,
  output logic [SCR1_IR_WIDTH-1:0] ir
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_t;
  localparam logic [SCR1_IR_WIDTH-1:0] IR_CAP = SCR1_IR_WIDTH'(1);
  localparam logic [SCR1_IR_WIDTH-1:0] IR_RST = SCR1_IR_WIDTH'(SCR1_IR_RESET);
  state_t state, next;
  logic [SCR1_IR_WIDTH-1:0] ir_sr;
  logic bypass;
  logic ext_sel;
  logic ext_dout;
  // TAP state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= TLR;
    else state <= next;
  // IEEE 1149.1 next-state function driven by tms
  always_comb begin
    next = state;
    case (state)
      TLR:    next = tms ? TLR    : RTI;
      RTI:    next = tms ? SEL_DR : RTI;
      SEL_DR: next = tms ? SEL_IR : CAP_DR;
      CAP_DR: next = tms ? EX1_DR : SH_DR;
      SH_DR:  next = tms ? EX1_DR : SH_DR;
      EX1_DR: next = tms ? UPD_DR : PAU_DR;
      PAU_DR: next = tms ? EX2_DR : PAU_DR;
      EX2_DR: next = tms ? UPD_DR : SH_DR;
      UPD_DR: next = tms ? SEL_DR : RTI;
      SEL_IR: next = tms ? TLR    : CAP_IR;
      CAP_IR: next = tms ? EX1_IR : SH_IR;
      SH_IR:  next = tms ? EX1_IR : SH_IR;
      EX1_IR: next = tms ? UPD_IR : PAU_IR;
      PAU_IR: next = tms ? EX2_IR : PAU_IR;
      EX2_IR: next = tms ? UPD_IR : SH_IR;
      UPD_IR: next = tms ? SEL_DR : RTI;
    endcase
  end
  // DR strobes and sync reset decoded from the state register alone
  always_comb begin
    fsm_dr_capture = state == CAP_DR;
    fsm_dr_shift   = state == SH_DR;
    fsm_dr_update  = state == UPD_DR;
    rst_n_sync     = state != TLR;
  end
  // IR shift register: capture the fixed 01 pattern, shift LSB-first toward tdo
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ir_sr <= IR_CAP;
    else if (state == CAP_IR) ir_sr <= IR_CAP;
    else if (state == SH_IR) ir_sr <= {tdi, ir_sr[SCR1_IR_WIDTH-1:1]};
  // IR shadow updates on the falling edge so the DRs see a stable select
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) ir <= IR_RST;
    else if (state == TLR) ir <= IR_RST;
    else if (state == UPD_IR) ir <= ir_sr;
  // BYPASS cell: captures 0, shifts tdi
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bypass <= 1'b0;
    else if (state == TLR || state == CAP_DR) bypass <= 1'b0;
    else if (state == SH_DR) bypass <= tdi;
  for (genvar g = 0; g < SCR1_NUM_DR; g++) begin : g_sel
    assign fsm_dr_select[g] = ir == SCR1_IR_WIDTH'(g);
  end
  assign ext_sel  = |fsm_dr_select;
  assign ext_dout = |(dr_dout_serial & fsm_dr_select);
  // TDO mux registered on the falling edge; BYPASS when no external DR matches
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= state == SH_IR ? ir_sr[0] : state == SH_DR ? (ext_sel ? ext_dout : bypass) : 1'b0;
      tdo_en <= state == SH_IR || state == SH_DR;
    end
endmodule

// File: tb/tb_scr1_tapc_ctrl.sv
// tb_scr1_tapc_ctrl: scoreboard-driven bench for the TAP controller
module tb_scr1_tapc_ctrl;
  localparam int W = 5;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic [N-1:0] dr_dout_serial = '0;
  logic tdo, tdo_en, fsm_dr_capture, fsm_dr_shift, fsm_dr_update, rst_n_sync;
  logic [N-1:0] fsm_dr_select;
  logic [W-1:0] ir;
  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  scr1_tapc_ctrl #(.SCR1_IR_WIDTH(W), .SCR1_NUM_DR(N), .SCR1_IR_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .tms(tms), .tdi(tdi), .dr_dout_serial(dr_dout_serial),
    .tdo(tdo), .tdo_en(tdo_en), .fsm_dr_select(fsm_dr_select),
    .fsm_dr_capture(fsm_dr_capture), .fsm_dr_shift(fsm_dr_shift),
    .fsm_dr_update(fsm_dr_update), .rst_n_sync(rst_n_sync), .ir(ir)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [W-1:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < W; i++) step(i == W - 1, v[i]);
    step(1, 0); step(0, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tms = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({tdo, tdo_en, rst_n_sync, fsm_dr_capture, fsm_dr_shift, fsm_dr_update} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {tdo, tdo_en, rst_n_sync, fsm_dr_capture, fsm_dr_shift, fsm_dr_update});
    end
    checks++;
    if ({ir, fsm_dr_select} !== {5'd1, 4'b0010}) begin
      errors++;
      $display("FAIL reset_ir: got ir=%0d sel=%b expected ir=1 sel=0010", ir, fsm_dr_select);
    end
    rst_n = 1'b1;
    repeat (3) step(1, 0);
    checks++;
    if ({rst_n_sync, ir, fsm_dr_select} !== {1'b0, 5'd1, 4'b0010}) begin
      errors++;
      $display("FAIL tlr_hold: got sync=%b ir=%0d sel=%b expected sync=0 ir=1 sel=0010", rst_n_sync, ir, fsm_dr_select);
    end
    step(0, 0);
    checks++;
    if (rst_n_sync !== 1'b1) begin
      errors++;
      $display("FAIL rti_entry: got sync=%b expected 1", rst_n_sync);
    end
  endtask

  task automatic test_ir_scan;
    logic [W-1:0] v = 5'b00011;
    bit e;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    exp_q = '{1, 0, 0, 0, 0};
    for (int i = 0; i < W; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({tdo_en, tdo} !== {1'b1, e}) begin
        errors++;
        $display("FAIL ir_scan_tdo[%0d]: got en=%b tdo=%b expected en=1 tdo=%b", i, tdo_en, tdo, e);
      end
      step(i == W - 1, v[i]);
    end
    checks++;
    if (tdo_en !== 1'b0) begin
      errors++;
      $display("FAIL ir_scan_exit: got en=%b expected 0", tdo_en);
    end
    step(1, 0);
    checks++;
    if ({ir, fsm_dr_select} !== {5'd3, 4'b1000}) begin
      errors++;
      $display("FAIL ir_update: got ir=%0d sel=%b expected ir=3 sel=1000", ir, fsm_dr_select);
    end
    step(0, 0);
  endtask

  task automatic test_dr_strobes;
    logic [8:0] tv = 9'b011000001;
    logic [3:0] p = 4'b1101;
    int ncap = 0, nsh = 0, nupd = 0, cap_at = 0, upd_at = 0;
    bit e;
    load_ir(5'd2);
    for (int k = 1; k <= 9; k++) begin
      if (k >= 3 && k <= 6) begin
        dr_dout_serial = p[k-3] ? 4'b0100 : 4'b1011;
        exp_q.push_back(p[k-3]);
      end
      step(tv[k-1], 0);
      if (fsm_dr_capture) begin ncap++; cap_at = k; end
      if (fsm_dr_shift) nsh++;
      if (fsm_dr_update) begin nupd++; upd_at = k; end
      checks++;
      if (fsm_dr_select !== 4'b0100) begin
        errors++;
        $display("FAIL dr_select[%0d]: got %b expected 0100", k, fsm_dr_select);
      end
      checks++;
      if (tdo_en !== (k >= 3 && k <= 6)) begin
        errors++;
        $display("FAIL dr_tdo_en[%0d]: got %b expected %b", k, tdo_en, k >= 3 && k <= 6);
      end
      if (k >= 3 && k <= 6) begin
        e = exp_q.pop_front();
        checks++;
        if (tdo !== e) begin
          errors++;
          $display("FAIL dr_tdo[%0d]: got %b expected %b", k, tdo, e);
        end
      end
    end
    checks++;
    if (ncap != 1 || nsh != 4 || nupd != 1 || cap_at != 2 || upd_at != 8) begin
      errors++;
      $display("FAIL dr_strobes: got cap=%0d@%0d sh=%0d upd=%0d@%0d expected cap=1@2 sh=4 upd=1@8", ncap, cap_at, nsh, nupd, upd_at);
    end
    dr_dout_serial = '0;
  endtask

  task automatic test_bypass;
    logic [3:0] b = 4'b1101;
    bit e;
    load_ir(5'h1f);
    checks++;
    if (fsm_dr_select !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_select: got %b expected 0000", fsm_dr_select);
    end
    dr_dout_serial = 4'b1111;
    step(1, 0); step(0, 0); step(0, 0);
    exp_q = '{0};
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({tdo_en, tdo} !== {1'b1, e}) begin
        errors++;
        $display("FAIL bypass_tdo[%0d]: got en=%b tdo=%b expected en=1 tdo=%b", i, tdo_en, tdo, e);
      end
      exp_q.push_back(b[i]);
      step(i == 3, b[i]);
    end
    exp_q.delete();
    step(1, 0); step(0, 0);
    dr_dout_serial = '0;
  endtask

  task automatic test_pause_resume;
    logic [W-1:0] v = 5'b10110;
    logic [9:0] obs = 10'b1110000011;
    logic [9:0] tm = 10'b1000100010;
    int j = 0;
    bit e;
    logic d;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    exp_q = '{1, 0, 0, 0, 0};
    for (int k = 0; k < 10; k++) begin
      d = 1'b0;
      if (obs[k]) begin
        e = exp_q.pop_front();
        checks++;
        if ({tdo_en, tdo} !== {1'b1, e}) begin
          errors++;
          $display("FAIL pause_tdo[%0d]: got en=%b tdo=%b expected en=1 tdo=%b", k, tdo_en, tdo, e);
        end
        d = v[j];
        j++;
      end else begin
        checks++;
        if (tdo_en !== 1'b0) begin
          errors++;
          $display("FAIL pause_tdo_en[%0d]: got %b expected 0", k, tdo_en);
        end
      end
      step(tm[k], d);
    end
    step(1, 0);
    checks++;
    if ({ir, fsm_dr_select} !== {5'd22, 4'b0000}) begin
      errors++;
      $display("FAIL pause_ir: got ir=%0d sel=%b expected ir=22 sel=0000", ir, fsm_dr_select);
    end
    step(0, 0);
  endtask

  task automatic test_async_reset;
    bit e;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    repeat (3) step(0, 1);
    checks++;
    if (tdo_en !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got en=%b expected 1", tdo_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rst_n_sync, tdo_en, tdo, ir, fsm_dr_select} !== {1'b0, 1'b0, 1'b0, 5'd1, 4'b0010}) begin
      errors++;
      $display("FAIL arst_now: got sync=%b en=%b tdo=%b ir=%0d sel=%b expected 0 0 0 1 0010", rst_n_sync, tdo_en, tdo, ir, fsm_dr_select);
    end
    #1;
    rst_n = 1'b1;
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    exp_q = '{1, 0, 0, 0, 0};
    for (int i = 0; i < W; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({tdo_en, tdo} !== {1'b1, e}) begin
        errors++;
        $display("FAIL arst_cap[%0d]: got en=%b tdo=%b expected en=1 tdo=%b", i, tdo_en, tdo, e);
      end
      step(i == W - 1, 1);
    end
    step(1, 0);
    checks++;
    if (ir !== 5'd31) begin
      errors++;
      $display("FAIL arst_ir: got %0d expected 31", ir);
    end
    step(0, 0);
  endtask

  task automatic test_tlr_escape;
    step(1, 0); step(0, 0); step(0, 0);
    checks++;
    if (fsm_dr_shift !== 1'b1) begin
      errors++;
      $display("FAIL esc_shift: got %b expected 1", fsm_dr_shift);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      checks++;
      if (rst_n_sync !== (i != 4)) begin
        errors++;
        $display("FAIL esc_step[%0d]: got sync=%b expected %b", i, rst_n_sync, i != 4);
      end
    end
    checks++;
    if ({ir, fsm_dr_select} !== {5'd1, 4'b0010}) begin
      errors++;
      $display("FAIL esc_ir: got ir=%0d sel=%b expected ir=1 sel=0010", ir, fsm_dr_select);
    end
  endtask

  initial begin
    test_reset;
    test_ir_scan;
    test_dr_strobes;
    test_bypass;
    test_pause_resume;
    test_async_reset;
    test_tlr_escape;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
